wb_trace_buffer: RTL and testbench

- Commit-trace capture block sitting directly downstream of the pipelined CPU's write-back stage.
- Samples every architecturally visible register write (PC, destination register, write data) from the WB-stage outputs and timestamps it with a sequence number.
- Buffers events in a FIFO and streams each event out as three 32-bit words over a valid/ready interface, for a UART/JTAG dumper or the simulation checker.
- Counts events lost to overflow so gaps in the trace are detectable.

---
 rtl/wb_trace_buffer_if.sv | 13 +
 rtl/wb_trace_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_trace_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: valid/ready trace-word stream (3 words per event, last on the third).
// master = trace buffer (producer), slave = dumper/checker (consumer).
`timescale 1ns/1ps

interface wb_trace_buffer_if;
  logic [31:0] tr_data_o;
  logic        tr_valid_o;
  logic        tr_last_o;
  logic        tr_ready_i;

  modport master (output tr_data_o, output tr_valid_o, output tr_last_o, input tr_ready_i);
  modport slave  (input tr_data_o, input tr_valid_o, input tr_last_o, output tr_ready_i);
endinterface

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: commit-trace capture behind the WB stage. Register writes are tagged
// with a sequence number, queued in a FIFO and streamed as {hdr, pc, data} word triples.
// Optional store capture through a one-entry skid register: define TRACE_MEM_WR_EN.
`timescale 1ns/1ps

module wb_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       trace_en_i,
  input  logic                       rf_we_i,
  input  logic [4:0]                 rf_wr_i,
  input  logic [31:0]                rf_wd_i,
  input  logic [31:0]                wb_pc_i,
  input  logic                       mem_we_i,
  input  logic [13:0]                mem_adr_i,
  input  logic [31:0]                mem_wd_i,
  wb_trace_buffer_if.master          tr,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic             typ;
    logic [4:0]       wr;
    logic [31:0]      pc;
    logic [31:0]      wd;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;

  function automatic logic [31:0] hdr_word(input entry_t e);
    return {e.seq, 8'h00, e.typ, 2'b00, e.wr};
  endfunction

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [SEQ_W-1:0] r_seq;
  logic [15:0]      r_drop_cnt;
  logic             r_overflow;
  state_t           r_state, w_state_nxt;
  logic [31:0]      r_tr_data, w_data_nxt;
  logic             r_tr_valid, w_valid_nxt;
  logic             r_tr_last, w_last_nxt;
  logic [31:0]      r_hold_pc, r_hold_wd;

  logic   w_empty, w_full, w_load, w_space;
  logic   w_rf_evt, w_rf_push, w_rf_drop;
  logic   w_skid_push, w_st_cap, w_st_drop, w_push;
  entry_t w_head, w_rf_entry, w_skid_entry, w_push_entry;
  logic [1:0]  w_seq_inc, w_drop_inc;
  logic [16:0] w_drop_sum;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_head   = r_mem[r_rd_ptr];
  assign w_space  = !w_full || w_load;
  assign w_rf_evt = trace_en_i & rf_we_i & (rf_wr_i != 5'd0);

  assign w_rf_push  = w_rf_evt & w_space;
  assign w_rf_drop  = w_rf_evt & ~w_space;
  assign w_rf_entry = '{seq: r_seq, typ: 1'b0, wr: rf_wr_i, pc: wb_pc_i, wd: rf_wd_i};

`ifdef TRACE_MEM_WR_EN
  entry_t r_skid;
  logic   r_skid_vld;
  logic   w_st_evt;

  // A store waits in the skid until a cycle with no rf event and room in the FIFO;
  // a store arriving in the same cycle the skid drains still gets captured.
  assign w_st_evt     = trace_en_i & mem_we_i;
  assign w_skid_push  = r_skid_vld & ~w_rf_evt & w_space;
  assign w_st_cap     = w_st_evt & (~r_skid_vld | w_skid_push);
  assign w_st_drop    = w_st_evt & ~w_st_cap;
  assign w_skid_entry = r_skid;

  // Skid register; a store in MEM is younger than the WB write, so it takes the later seq.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
    end else if (clear_i) begin
      r_skid_vld <= 1'b0;
    end else if (w_st_cap) begin
      r_skid_vld <= 1'b1;
      r_skid     <= '{seq: w_rf_evt ? r_seq + SEQ_W'(1) : r_seq, typ: 1'b1, wr: 5'd0,
                      pc: 32'(mem_adr_i), wd: mem_wd_i};
    end else if (w_skid_push) begin
      r_skid_vld <= 1'b0;
    end
  end
`else
  logic w_unused_mem;

  assign w_unused_mem = ^{mem_we_i, mem_adr_i, mem_wd_i};
  assign w_skid_push  = 1'b0;
  assign w_st_cap     = 1'b0;
  assign w_st_drop    = 1'b0;
  assign w_skid_entry = '0;
`endif

  assign w_push       = w_rf_push | w_skid_push;
  assign w_push_entry = w_rf_evt ? w_rf_entry : w_skid_entry;
  assign w_seq_inc    = 2'(w_rf_evt) + 2'(w_st_cap);
  assign w_drop_inc   = 2'(w_rf_drop) + 2'(w_st_drop);
  assign w_drop_sum   = 17'(r_drop_cnt) + 17'(w_drop_inc);

  // FIFO storage, no reset needed: pointers/level define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) r_mem[r_wr_ptr] <= w_push_entry;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_load);
    end
  end

  // Sequence number, saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_seq      <= r_seq + SEQ_W'(w_seq_inc);
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (w_drop_inc != 2'd0) r_overflow <= 1'b1;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     r_state <= S_IDLE;
    else if (clear_i) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Output FSM next state: W0..W2 advance on ready, W2 chains straight into the next entry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_nxt = S_W0;
      S_W0:   if (tr.tr_ready_i) w_state_nxt = S_W1;
      S_W1:   if (tr.tr_ready_i) w_state_nxt = S_W2;
      S_W2:   if (tr.tr_ready_i) w_state_nxt = w_empty ? S_IDLE : S_W0;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output FSM outputs: head pop and next values of the registered stream word.
  always_comb begin
    w_load      = 1'b0;
    w_data_nxt  = r_tr_data;
    w_valid_nxt = r_tr_valid;
    w_last_nxt  = r_tr_last;
    case (r_state)
      S_IDLE: if (!w_empty) w_load = 1'b1;
      S_W0: if (tr.tr_ready_i) w_data_nxt = r_hold_pc;
      S_W1: if (tr.tr_ready_i) begin
        w_data_nxt = r_hold_wd;
        w_last_nxt = 1'b1;
      end
      S_W2: if (tr.tr_ready_i) begin
        if (!w_empty) begin
          w_load = 1'b1;
        end else begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
    if (w_load) begin
      w_data_nxt  = hdr_word(w_head);
      w_valid_nxt = 1'b1;
      w_last_nxt  = 1'b0;
    end
  end

  // Registered stream outputs plus the pc/data of the entry being sent.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tr_data  <= '0;
      r_tr_valid <= 1'b0;
      r_tr_last  <= 1'b0;
      r_hold_pc  <= '0;
      r_hold_wd  <= '0;
    end else if (clear_i) begin
      r_tr_data  <= '0;
      r_tr_valid <= 1'b0;
      r_tr_last  <= 1'b0;
    end else begin
      r_tr_data  <= w_data_nxt;
      r_tr_valid <= w_valid_nxt;
      r_tr_last  <= w_last_nxt;
      if (w_load) begin
        r_hold_pc <= w_head.pc;
        r_hold_wd <= w_head.wd;
      end
    end
  end

  assign tr.tr_data_o  = r_tr_data;
  assign tr.tr_valid_o = r_tr_valid;
  assign tr.tr_last_o  = r_tr_last;
  assign level_o       = r_level;
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed bench for wb_trace_buffer with DEPTH=4.
`timescale 1ns/1ps

module tb_wb_trace_buffer;

  logic        clk, rst_n, clear, trace_en, rf_we, mem_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd, wb_pc, mem_wd;
  logic [13:0] mem_adr;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  int          n_cmp, n_err;
  logic [31:0] exp_w [9];
  logic [31:0] exp_v;

  wb_trace_buffer_if tr_if ();

  wb_trace_buffer #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .trace_en_i(trace_en),
    .rf_we_i(rf_we), .rf_wr_i(rf_wr), .rf_wd_i(rf_wd), .wb_pc_i(wb_pc),
    .mem_we_i(mem_we), .mem_adr_i(mem_adr), .mem_wd_i(mem_wd),
    .tr(tr_if), .level_o(level), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ev(input logic [4:0] wr, input logic [31:0] pc, input logic [31:0] wd);
    rf_we = 1'b1; rf_wr = wr; wb_pc = pc; rf_wd = wd;
  endtask

  task automatic noev();
    rf_we = 1'b0; rf_wr = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; clear = 1'b0; trace_en = 1'b0; rf_we = 1'b0; rf_wr = '0;
    rf_wd = '0; wb_pc = '0; mem_we = 1'b0; mem_adr = '0; mem_wd = '0;
    tr_if.tr_ready_i = 1'b0;
    step(); step();
    chk("rst_valid", 32'(tr_if.tr_valid_o), 32'd0);
    chk("rst_last",  32'(tr_if.tr_last_o), 32'd0);
    chk("rst_data",  tr_if.tr_data_o, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);

    // x0 write is not traced and does not consume a seq
    rst_n = 1'b1; trace_en = 1'b1; tr_if.tr_ready_i = 1'b1;
    step();
    ev(5'd0, 32'h8, 32'h55);
    step(); noev();
    step();
    chk("x0_valid", 32'(tr_if.tr_valid_o), 32'd0);
    chk("x0_level", 32'(level), 32'd0);
    step();
    chk("x0_valid2", 32'(tr_if.tr_valid_o), 32'd0);

    // basic event, N+2 latency
    ev(5'd5, 32'h10, 32'hDEADBEEF);
    step(); noev();
    chk("lat1_valid", 32'(tr_if.tr_valid_o), 32'd0);
    chk("lat1_level", 32'(level), 32'd1);
    step();
    chk("w0_valid", 32'(tr_if.tr_valid_o), 32'd1);
    chk("w0_data",  tr_if.tr_data_o, 32'h00000005);
    chk("w0_last",  32'(tr_if.tr_last_o), 32'd0);
    step();
    chk("w1_data",  tr_if.tr_data_o, 32'h00000010);
    chk("w1_last",  32'(tr_if.tr_last_o), 32'd0);
    step();
    chk("w2_data",  tr_if.tr_data_o, 32'hDEADBEEF);
    chk("w2_last",  32'(tr_if.tr_last_o), 32'd1);
    step();
    chk("end_valid", 32'(tr_if.tr_valid_o), 32'd0);
    chk("end_last",  32'(tr_if.tr_last_o), 32'd0);

    // back-pressure, then back-to-back drain with no bubbles
    clear = 1'b1; step(); clear = 1'b0;
    tr_if.tr_ready_i = 1'b0;
    ev(5'd1, 32'h100, 32'hA0A0A0A0); step();
    ev(5'd2, 32'h104, 32'hB0B0B0B0); step();
    ev(5'd3, 32'h108, 32'hC0C0C0C0); step();
    noev();
    chk("hold_level", 32'(level), 32'd2);
    chk("hold_data",  tr_if.tr_data_o, 32'h00000001);
    step();
    chk("hold_valid2", 32'(tr_if.tr_valid_o), 32'd1);
    chk("hold_data2",  tr_if.tr_data_o, 32'h00000001);
    exp_w = '{32'h00000001, 32'h100, 32'hA0A0A0A0,
              32'h00010002, 32'h104, 32'hB0B0B0B0,
              32'h00020003, 32'h108, 32'hC0C0C0C0};
    tr_if.tr_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_valid%0d", i), 32'(tr_if.tr_valid_o), 32'd1);
      chk($sformatf("b2b_data%0d", i), tr_if.tr_data_o, exp_w[i]);
      chk($sformatf("b2b_last%0d", i), 32'(tr_if.tr_last_o), (i % 3 == 2) ? 32'd1 : 32'd0);
      step();
    end
    chk("b2b_idle", 32'(tr_if.tr_valid_o), 32'd0);

    // overflow: 7 events into output reg + 4-entry FIFO, events 5 and 6 dropped
    clear = 1'b1; step(); clear = 1'b0;
    tr_if.tr_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ev(5'(i + 1), 32'h200 + 32'(4 * i), 32'(i));
      step();
    end
    noev();
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_drop",  32'(drop_cnt), 32'd2);
    chk("ovf_flag",  32'(overflow), 32'd1);
    tr_if.tr_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 0)      exp_v = {16'(i / 3), 8'h00, 8'(i / 3 + 1)};
      else if (i % 3 == 1) exp_v = 32'h200 + 32'(4 * (i / 3));
      else                 exp_v = 32'(i / 3);
      chk($sformatf("drain_valid%0d", i), 32'(tr_if.tr_valid_o), 32'd1);
      chk($sformatf("drain_data%0d", i), tr_if.tr_data_o, exp_v);
      step();
    end
    chk("drain_idle",  32'(tr_if.tr_valid_o), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_drop",  32'(drop_cnt), 32'd2);
    ev(5'd9, 32'h300, 32'h77);
    step(); noev();
    step();
    chk("gap_seq", tr_if.tr_data_o, 32'h00070009);
    step(); step(); step();
    chk("gap_idle", 32'(tr_if.tr_valid_o), 32'd0);

    // async reset during W1 aborts the entry
    ev(5'd4, 32'h400, 32'h44); step();
    ev(5'd6, 32'h404, 32'h66); step();
    noev(); step();
    chk("mid_w1", tr_if.tr_data_o, 32'h400);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(tr_if.tr_valid_o), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_drop",  32'(drop_cnt), 32'd0);
    chk("mid_rst_ovf",   32'(overflow), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("mid_after1", 32'(tr_if.tr_valid_o), 32'd0);
    step();
    chk("mid_after2", 32'(tr_if.tr_valid_o), 32'd0);

    // clear wins over a same-cycle event
    clear = 1'b1; ev(5'd7, 32'h500, 32'h55);
    step(); clear = 1'b0; noev();
    chk("clr_level", 32'(level), 32'd0);
    step();
    chk("clr_valid", 32'(tr_if.tr_valid_o), 32'd0);
    step();
    chk("clr_valid2", 32'(tr_if.tr_valid_o), 32'd0);
    ev(5'd2, 32'h600, 32'h66);
    step(); noev();
    step();
    chk("clr_seq0", tr_if.tr_data_o, 32'h00000002);
    step(); step(); step();

`ifdef TRACE_MEM_WR_EN
    // store capture through the skid register
    clear = 1'b1; step(); clear = 1'b0;
    mem_we = 1'b1; mem_adr = 14'h0040; mem_wd = 32'h12;
    step(); mem_we = 1'b0;
    step(); step();
    chk("st_w0_valid", 32'(tr_if.tr_valid_o), 32'd1);
    chk("st_w0", tr_if.tr_data_o, 32'h00000080);
    step();
    chk("st_w1", tr_if.tr_data_o, 32'h00000040);
    step();
    chk("st_w2", tr_if.tr_data_o, 32'h00000012);
    chk("st_last", 32'(tr_if.tr_last_o), 32'd1);
    step();
    chk("st_idle", 32'(tr_if.tr_valid_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
